// File: rtl/compuertas_barrido_if.sv
// ============================================================================
// Module      : compuertas_barrido_if
// Description : Control and result bundle of the gate sweep block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface compuertas_barrido_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] in_vec;
    logic [WIDTH-1:0] vec_out;
    logic             s_and;
    logic             s_or;
    logic             s_xor;
    logic             s_nand;
    logic             valid;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   cnt_and;
    logic [WIDTH:0]   cnt_or;
    logic [WIDTH:0]   cnt_xor;
    logic [WIDTH:0]   cnt_nand;

    modport master (
        output start, mode, in_vec,
        input  vec_out, s_and, s_or, s_xor, s_nand, valid, busy, done,
        input  cnt_and, cnt_or, cnt_xor, cnt_nand
    );

    modport slave (
        input  start, mode, in_vec,
        output vec_out, s_and, s_or, s_xor, s_nand, valid, busy, done,
        output cnt_and, cnt_or, cnt_xor, cnt_nand
    );
endinterface

`default_nettype wire

// File: rtl/compuertas_barrido.sv
// ============================================================================
// Module      : compuertas_barrido
// Description : Registered AND/OR/XOR/NAND gate evaluator with manual mode
//               and an exhaustive input sweep that counts output ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module compuertas_barrido #(
    parameter int WIDTH = 3,
    parameter int HOLD  = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    compuertas_barrido_if.slave    bus
);
    localparam int               C_HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD - 1);
    localparam logic [WIDTH-1:0] C_VEC_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        vec_q, vec_d;
    logic [3:0]              gates_q, gates_d;   // {nand, xor, or, and}
    logic                    valid_q, valid_d;
    logic [C_HOLD_W-1:0]     hold_q, hold_d;
    logic [3:0][WIDTH:0]     cnt_q, cnt_d;

    function automatic logic [3:0] gate_eval(input logic [WIDTH-1:0] v);
        return {~&v, ^v, |v, &v};
    endfunction

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        gates_d = gates_q;
        valid_d = 1'b0;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (!bus.mode) begin
                    vec_d   = bus.in_vec;
                    gates_d = gate_eval(bus.in_vec);
                    valid_d = 1'b1;
                end else if (bus.start) begin
                    // Counters restart from the results of vector 0.
                    state_d = S_SWEEP;
                    vec_d   = '0;
                    gates_d = gate_eval('0);
                    valid_d = 1'b1;
                    hold_d  = '0;
                    for (int i = 0; i < 4; i++) begin
                        cnt_d[i] = (WIDTH+1)'(gates_d[i]);
                    end
                end
            end

            S_SWEEP: begin
                if (hold_q == C_HOLD_LAST) begin
                    hold_d = '0;
                    if (vec_q == C_VEC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + WIDTH'(1);
                        gates_d = gate_eval(vec_d);
                        valid_d = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            cnt_d[i] = cnt_q[i] + (WIDTH+1)'(gates_d[i]);
                        end
                    end
                end else begin
                    hold_d = hold_q + C_HOLD_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            gates_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            gates_q <= gates_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status flags decode the registered state, so no input reaches an output.
    assign bus.vec_out  = vec_q;
    assign bus.s_and    = gates_q[0];
    assign bus.s_or     = gates_q[1];
    assign bus.s_xor    = gates_q[2];
    assign bus.s_nand   = gates_q[3];
    assign bus.valid    = valid_q;
    assign bus.busy     = (state_q == S_SWEEP);
    assign bus.done     = (state_q == S_DONE);
    assign bus.cnt_and  = cnt_q[0];
    assign bus.cnt_or   = cnt_q[1];
    assign bus.cnt_xor  = cnt_q[2];
    assign bus.cnt_nand = cnt_q[3];

endmodule

`default_nettype wire

// File: tb/tb_compuertas_barrido.sv
// ============================================================================
// Module      : tb_compuertas_barrido
// Description : Scoreboard bench running HOLD=1 and HOLD=2 instances in
//               parallel against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_compuertas_barrido;
    localparam int W = 3;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [W-1:0] in_vec;
    int           checks   = 0;
    int           failures = 0;
    bit           armed    = 1'b0;

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [W-1:0] vec;
        bit         done;
    } ev_t;

    // Gate truth from counting rules: g 0=and 1=or 2=xor 3=nand.
    function automatic bit ref_gate(input int g, input logic [W-1:0] v);
        case (g)
            0:       return (int'(v) == N - 1);
            1:       return (int'(v) != 0);
            2:       return ($countones(v) % 2) == 1;
            default: return (int'(v) != N - 1);
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int H = g + 1;

        compuertas_barrido_if #(.WIDTH(W)) u_if ();
        assign u_if.start  = start;
        assign u_if.mode   = mode;
        assign u_if.in_vec = in_vec;

        compuertas_barrido #(.WIDTH(W), .HOLD(H)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if.slave)
        );

        ev_t          q[$];
        ev_t          e;
        int           lcyc      = 0;
        bit           sweeping  = 1'b0;
        int           c0        = 0;
        int           done_edge = -100;
        logic [W-1:0] m_vec     = '0;
        bit           m_gz      = 1'b1;
        bit           m_busy    = 1'b0;
        int           m_cnt[4]  = '{0, 0, 0, 0};
        logic [3:0]   eg, ag;

        always @(posedge clk) begin
            lcyc++;
            if (!rst_n) begin
                sweeping = 1'b0;
                m_busy   = 1'b0;
                m_vec    = '0;
                m_gz     = 1'b1;
                m_cnt    = '{0, 0, 0, 0};
                q.delete();
            end else if (sweeping) begin
                if (lcyc - c0 == N * H) begin
                    sweeping  = 1'b0;
                    m_busy    = 1'b0;
                    done_edge = lcyc;
                    e = '{cyc: lcyc, vec: m_vec, done: 1'b1};
                    q.push_back(e);
                end else if ((lcyc - c0) % H == 0) begin
                    m_vec = W'((lcyc - c0) / H);
                    for (int i = 0; i < 4; i++) m_cnt[i] += int'(ref_gate(i, m_vec));
                    e = '{cyc: lcyc, vec: m_vec, done: 1'b0};
                    q.push_back(e);
                end
            end else if (lcyc == done_edge + 1) begin
                m_busy = 1'b0;
            end else if (!mode) begin
                m_vec = in_vec;
                m_gz  = 1'b0;
                e = '{cyc: lcyc, vec: m_vec, done: 1'b0};
                q.push_back(e);
            end else if (start) begin
                sweeping = 1'b1;
                m_busy   = 1'b1;
                c0       = lcyc;
                m_vec    = '0;
                m_gz     = 1'b0;
                for (int i = 0; i < 4; i++) m_cnt[i] = int'(ref_gate(i, '0));
                e = '{cyc: lcyc, vec: m_vec, done: 1'b0};
                q.push_back(e);
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                eg = m_gz ? 4'b0000 : {ref_gate(3, m_vec), ref_gate(2, m_vec),
                                       ref_gate(1, m_vec), ref_gate(0, m_vec)};
                ag = {u_if.s_nand, u_if.s_xor, u_if.s_or, u_if.s_and};
                checks++;
                if (u_if.vec_out !== m_vec || ag !== eg || u_if.busy !== m_busy ||
                    u_if.cnt_and  !== (W+1)'(m_cnt[0]) || u_if.cnt_or  !== (W+1)'(m_cnt[1]) ||
                    u_if.cnt_xor  !== (W+1)'(m_cnt[2]) || u_if.cnt_nand !== (W+1)'(m_cnt[3])) begin
                    failures++;
                    $display("FAIL state hold=%0d cyc=%0d: got vec=%b gates=%b busy=%b cnt=%0d/%0d/%0d/%0d, required vec=%b gates=%b busy=%b cnt=%0d/%0d/%0d/%0d",
                             H, lcyc, u_if.vec_out, ag, u_if.busy, u_if.cnt_and, u_if.cnt_or,
                             u_if.cnt_xor, u_if.cnt_nand, m_vec, eg, m_busy,
                             m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
                end
                if (u_if.valid === 1'b1 || u_if.done === 1'b1) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event hold=%0d cyc=%0d: got valid=%b done=%b, required none",
                                 H, lcyc, u_if.valid, u_if.done);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != lcyc || u_if.done !== e.done || u_if.valid !== !e.done ||
                            u_if.vec_out !== e.vec) begin
                            failures++;
                            $display("FAIL event hold=%0d cyc=%0d: got valid=%b done=%b vec=%b, required cyc=%0d valid=%b done=%b vec=%b",
                                     H, lcyc, u_if.valid, u_if.done, u_if.vec_out,
                                     e.cyc, !e.done, e.done, e.vec);
                        end
                    end
                end else if (q.size() != 0) begin
                    checks++;
                    failures++;
                    e = q.pop_front();
                    $display("FAIL missed_event hold=%0d cyc=%0d: got valid=%b done=%b, required valid=%b done=%b vec=%b",
                             H, lcyc, u_if.valid, u_if.done, !e.done, e.done, e.vec);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit m, input logic [W-1:0] v);
        @(negedge clk);
        start  = s;
        mode   = m;
        in_vec = v;
    endtask

    task automatic chk_final(input string tag);
        chk({tag, "_and0"},  int'(g_inst[0].u_if.cnt_and),  1);
        chk({tag, "_or0"},   int'(g_inst[0].u_if.cnt_or),   7);
        chk({tag, "_xor0"},  int'(g_inst[0].u_if.cnt_xor),  4);
        chk({tag, "_nand0"}, int'(g_inst[0].u_if.cnt_nand), 7);
        chk({tag, "_or1"},   int'(g_inst[1].u_if.cnt_or),   7);
        chk({tag, "_xor1"},  int'(g_inst[1].u_if.cnt_xor),  4);
    endtask

    initial begin
        bit found;
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 1'b1;
        in_vec = '0;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_vec",   int'(g_inst[0].u_if.vec_out), 0);
        chk("rst_nand",  int'(g_inst[0].u_if.s_nand),  0);
        chk("rst_valid", int'(g_inst[0].u_if.valid),   0);

        rst_n  = 1'b1;
        mode   = 1'b0;
        in_vec = 3'b011;
        @(negedge clk);
        chk("man_vec",   int'(g_inst[0].u_if.vec_out), 3);
        chk("man_and",   int'(g_inst[0].u_if.s_and),   0);
        chk("man_or",    int'(g_inst[0].u_if.s_or),    1);
        chk("man_xor",   int'(g_inst[0].u_if.s_xor),   0);
        chk("man_nand",  int'(g_inst[0].u_if.s_nand),  1);
        chk("man_valid", int'(g_inst[0].u_if.valid),   1);

        repeat (8) drive(1'($urandom % 2), 1'b0, W'($urandom));
        repeat (3) drive(1'b0, 1'b1, W'($urandom));

        drive(1'b1, 1'b1, '0);
        repeat (20) drive(1'b0, 1'b1, W'($urandom));
        chk_final("sweep");

        // Interference with the HOLD=1 sweep still running.
        drive(1'b1, 1'b1, '0);
        repeat (7) drive(1'($urandom % 2), 1'($urandom % 2), W'($urandom));
        repeat (20) drive(1'b0, 1'b1, W'($urandom));
        chk_final("interf");

        drive(1'b1, 1'b1, '0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1'b0, 1'b1, '0);
            if (g_inst[0].u_if.vec_out === 3'd4 && g_inst[0].u_if.busy === 1'b1) found = 1'b1;
        end
        chk("mid_reach4", int'(found), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_busy",  int'(g_inst[0].u_if.busy),   0);
        chk("mid_done",  int'(g_inst[0].u_if.done),   0);
        chk("mid_cnt",   int'(g_inst[0].u_if.cnt_or), 0);
        drive(1'b1, 1'b1, '0);
        repeat (20) drive(1'b0, 1'b1, W'($urandom));
        chk_final("restart");

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rst_n  = ($urandom_range(0, 39) != 0);
            start  = ($urandom % 4 == 0);
            mode   = ($urandom % 3 != 0);
            in_vec = W'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) drive(1'b0, 1'b1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
